// File: rtl/tcdm_xbar_pipe.sv
// Tightly-coupled data memory crossbar. NumIn initiators reach NumOut
// word-interleaved banks. Each bank has its own round-robin arbiter and an
// optional registered request stage. Each bank also has a fixed-latency
// response pipeline that steers read data back to the initiator that was
// granted. Reset is synchronous and active-high.
module tcdm_xbar_pipe #(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned NumOut       = 8,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 10,
  parameter int unsigned RespLat      = 1,
  parameter bit          WriteRespOn  = 1'b1,
  parameter bit          ReqPipe      = 1'b0,
  parameter int unsigned IlvWords     = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  // initiator side
  input  logic [NumIn-1:0]                      req_i,
  input  logic [NumIn-1:0][AddrWidth-1:0]       add_i,
  input  logic [NumIn-1:0]                      wen_i,
  input  logic [NumIn-1:0][DataWidth-1:0]       wdata_i,
  input  logic [NumIn-1:0][BeWidth-1:0]         be_i,
  output logic [NumIn-1:0]                      gnt_o,
  output logic [NumIn-1:0]                      vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]       rdata_o,
  // bank side
  output logic [NumOut-1:0]                     req_o,
  output logic [NumOut-1:0][AddrMemWidth-1:0]   add_o,
  output logic [NumOut-1:0]                     wen_o,
  output logic [NumOut-1:0][DataWidth-1:0]      wdata_o,
  output logic [NumOut-1:0][BeWidth-1:0]        be_o,
  input  logic [NumOut-1:0]                     gnt_i,
  input  logic [NumOut-1:0][DataWidth-1:0]      rdata_i
);

  localparam int unsigned WOff     = $clog2(DataWidth / 8);
  localparam int unsigned Il       = $clog2(IlvWords);
  localparam int unsigned BankBits = $clog2(NumOut);
  localparam int unsigned BankW    = (NumOut > 1) ? BankBits : 1;
  localparam int unsigned IdW      = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned CalcW    = (AddrWidth > AddrMemWidth) ? AddrWidth : AddrMemWidth;

  // Bank index: the bits just above the in-bank interleave offset.
  function automatic logic [BankW-1:0] bank_of(input logic [AddrWidth-1:0] a);
    logic [AddrWidth-1:0] s;
    s = a >> (WOff + Il);
    return s[BankW-1:0] & BankW'(NumOut - 1);
  endfunction

  // In-bank word address: row bits above the bank field, then the interleave
  // offset bits below it. The result is truncated or zero-extended to
  // AddrMemWidth.
  function automatic logic [AddrMemWidth-1:0] waddr_of(input logic [AddrWidth-1:0] a);
    logic [CalcW-1:0] ext;
    logic [CalcW-1:0] upper;
    logic [CalcW-1:0] low;
    ext   = CalcW'(a);
    upper = ext >> (WOff + Il + BankBits);
    low   = (ext >> WOff) & CalcW'(IlvWords - 1);
    return AddrMemWidth'((upper << Il) | low);
  endfunction

  logic [NumIn-1:0][BankW-1:0]        bank_sel;
  logic [NumIn-1:0][AddrMemWidth-1:0] word_addr;
  logic [NumOut-1:0][NumIn-1:0]       bank_req;
  logic [NumOut-1:0]                  any_req;
  logic [NumOut-1:0][IdW-1:0]         win_id;
  logic [NumOut-1:0][IdW-1:0]         rr_q, rr_d;

  // Per-bank events shared by both request-stage variants.
  logic [NumOut-1:0]                  bank_load;  // initiator-side grant
  logic [NumOut-1:0]                  hs;         // req_o & gnt_i
  logic [NumOut-1:0][IdW-1:0]         hs_id;
  logic [NumOut-1:0]                  hs_wen;
  logic [NumOut-1:0]                  req_raw;

  // Address decode and the bank-by-initiator request matrix.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional code, so no path can leave it holding and infer a latch.
    bank_sel  = '0;
    word_addr = '0;
    bank_req  = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      bank_sel[i]  = bank_of(add_i[i]);
      word_addr[i] = waddr_of(add_i[i]);
    end
    for (int o = 0; o < int'(NumOut); o++) begin
      for (int i = 0; i < int'(NumIn); i++) begin
        bank_req[o][i] = req_i[i] && (bank_sel[i] == BankW'(o));
      end
    end
  end

  // Round-robin pick: scan downward so the offset nearest the pointer wins.
  always_comb begin : p_arb
    logic [IdW-1:0] cand;
    cand    = '0;
    any_req = '0;
    win_id  = '0;
    for (int o = 0; o < int'(NumOut); o++) begin
      for (int k = int'(NumIn) - 1; k >= 0; k--) begin
        cand = IdW'((int'(rr_q[o]) + k) % int'(NumIn));
        if (bank_req[o][cand]) begin
          any_req[o] = 1'b1;
          win_id[o]  = cand;
        end
      end
    end
  end

  // The pointer moves past the winner only when that bank grants an initiator.
  always_comb begin
    rr_d = rr_q;
    for (int o = 0; o < int'(NumOut); o++) begin
      if (bank_load[o]) begin
        rr_d[o] = (win_id[o] == IdW'(NumIn - 1)) ? '0 : win_id[o] + 1'b1;
      end
    end
  end

  // Arbitration pointer register.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments, so every register samples pre-edge
    // values regardless of the order in which the blocks are evaluated.
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  if (!ReqPipe) begin : gen_direct
    // The winner drives the bank directly, and the bank grant returns in the same cycle.
    always_comb begin
      req_raw   = any_req;
      add_o     = '0;
      wen_o     = '0;
      wdata_o   = '0;
      be_o      = '0;
      bank_load = '0;
      hs        = '0;
      hs_id     = win_id;
      hs_wen    = '0;
      for (int o = 0; o < int'(NumOut); o++) begin
        add_o[o]     = word_addr[win_id[o]];
        wen_o[o]     = wen_i[win_id[o]];
        wdata_o[o]   = wdata_i[win_id[o]];
        be_o[o]      = be_i[win_id[o]];
        bank_load[o] = any_req[o] && gnt_i[o];
        hs[o]        = any_req[o] && gnt_i[o];
        hs_wen[o]    = wen_i[win_id[o]];
      end
    end
  end else begin : gen_pipe
    logic [NumOut-1:0]                   ent_vld_q;
    logic [NumOut-1:0][IdW-1:0]          ent_id_q;
    logic [NumOut-1:0][AddrMemWidth-1:0] ent_add_q;
    logic [NumOut-1:0]                   ent_wen_q;
    logic [NumOut-1:0][DataWidth-1:0]    ent_wdata_q;
    logic [NumOut-1:0][BeWidth-1:0]      ent_be_q;

    // The entry refills when it is empty or is being drained this cycle.
    always_comb begin
      bank_load = '0;
      hs        = '0;
      for (int o = 0; o < int'(NumOut); o++) begin
        hs[o]        = ent_vld_q[o] && gnt_i[o];
        bank_load[o] = any_req[o] && (!ent_vld_q[o] || gnt_i[o]);
      end
      req_raw = ent_vld_q;
      add_o   = ent_add_q;
      wen_o   = ent_wen_q;
      wdata_o = ent_wdata_q;
      be_o    = ent_be_q;
      hs_id   = ent_id_q;
      hs_wen  = ent_wen_q;
    end

    // Entry occupancy.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ent_vld_q <= '0;
      end else begin
        for (int o = 0; o < int'(NumOut); o++) begin
          if (bank_load[o])  ent_vld_q[o] <= 1'b1;
          else if (hs[o])    ent_vld_q[o] <= 1'b0;
        end
      end
    end

    // Entry payload. It changes only on a load, so it stays stable while the bank stalls.
    always_ff @(posedge clk_i) begin
      // NOTE: payload is not reset; it is qualified by ent_vld_q, which is.
      for (int o = 0; o < int'(NumOut); o++) begin
        if (bank_load[o]) begin
          ent_id_q[o]    <= win_id[o];
          ent_add_q[o]   <= word_addr[win_id[o]];
          ent_wen_q[o]   <= wen_i[win_id[o]];
          ent_wdata_q[o] <= wdata_i[win_id[o]];
          ent_be_q[o]    <= be_i[win_id[o]];
        end
      end
    end
  end

  assign req_o = rst_i ? '0 : req_raw;

  // Initiator grants. Each initiator targets a single bank, so it receives at most one grant.
  always_comb begin
    gnt_o = '0;
    if (!rst_i) begin
      for (int o = 0; o < int'(NumOut); o++) begin
        if (bank_load[o]) gnt_o[win_id[o]] = 1'b1;
      end
    end
  end

  logic [NumOut-1:0][RespLat-1:0]          rsp_vld_q;
  logic [NumOut-1:0][RespLat-1:0]          rsp_wen_q;
  logic [NumOut-1:0][RespLat-1:0][IdW-1:0] rsp_id_q;

  // Fixed-latency response shift pipeline per bank. Reset discards in-flight transactions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_vld_q <= '0;
      rsp_wen_q <= '0;
      rsp_id_q  <= '0;
    end else begin
      for (int o = 0; o < int'(NumOut); o++) begin
        rsp_vld_q[o][0] <= hs[o];
        rsp_wen_q[o][0] <= hs_wen[o];
        rsp_id_q[o][0]  <= hs_id[o];
        for (int s = 1; s < int'(RespLat); s++) begin
          rsp_vld_q[o][s] <= rsp_vld_q[o][s-1];
          rsp_wen_q[o][s] <= rsp_wen_q[o][s-1];
          rsp_id_q[o][s]  <= rsp_id_q[o][s-1];
        end
      end
    end
  end

  // Route the last stage of each bank's pipeline back to its initiator. rdata_o is zero when vld_o is low.
  always_comb begin
    vld_o   = '0;
    rdata_o = '0;
    if (!rst_i) begin
      for (int o = 0; o < int'(NumOut); o++) begin
        if (rsp_vld_q[o][RespLat-1] && (!rsp_wen_q[o][RespLat-1] || WriteRespOn)) begin
          vld_o[rsp_id_q[o][RespLat-1]]   = 1'b1;
          rdata_o[rsp_id_q[o][RespLat-1]] = rdata_i[o];
        end
      end
    end
  end

endmodule

// File: tb/tb_tcdm_xbar_pipe.sv
// Directed bench for tcdm_xbar_pipe. Five instances share the same stimulus:
//   0: defaults   1: IlvWords=4   2: ReqPipe=1
//   3: RespLat=2, WriteRespOn=0   4: RespLat=2, WriteRespOn=1
// Bank b returns read data 0xD000_000b.
module tb_tcdm_xbar_pipe;

  localparam int NI = 4;
  localparam int NO = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MW = 10;
  localparam int ND = 5;

  logic clk = 1'b0;
  logic rst_i;
  logic [NI-1:0]         req_i, wen_i;
  logic [NI-1:0][AW-1:0] add_i;
  logic [NI-1:0][DW-1:0] wdata_i;
  logic [NI-1:0][BW-1:0] be_i;
  logic [NO-1:0]         gnt_i;
  logic [NO-1:0][DW-1:0] rdata_i;

  logic [NI-1:0]         gnt_o   [ND];
  logic [NI-1:0]         vld_o   [ND];
  logic [NI-1:0][DW-1:0] rdata_o [ND];
  logic [NO-1:0]         req_o   [ND];
  logic [NO-1:0][MW-1:0] add_o   [ND];
  logic [NO-1:0]         wen_o   [ND];
  logic [NO-1:0][DW-1:0] wdata_o [ND];
  logic [NO-1:0][BW-1:0] be_o    [ND];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : gen_dut
    tcdm_xbar_pipe #(
      .NumIn       (NI),
      .NumOut      (NO),
      .AddrWidth   (AW),
      .DataWidth   (DW),
      .BeWidth     (BW),
      .AddrMemWidth(MW),
      .RespLat     ((g >= 3) ? 2 : 1),
      .WriteRespOn ((g == 3) ? 1'b0 : 1'b1),
      .ReqPipe     ((g == 2) ? 1'b1 : 1'b0),
      .IlvWords    ((g == 1) ? 4 : 1)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst_i),
      .req_i  (req_i),
      .add_i  (add_i),
      .wen_i  (wen_i),
      .wdata_i(wdata_i),
      .be_i   (be_i),
      .gnt_o  (gnt_o[g]),
      .vld_o  (vld_o[g]),
      .rdata_o(rdata_o[g]),
      .req_o  (req_o[g]),
      .add_o  (add_o[g]),
      .wen_o  (wen_o[g]),
      .wdata_o(wdata_o[g]),
      .be_o   (be_o[g]),
      .gnt_i  (gnt_i),
      .rdata_i(rdata_i)
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_i   = '0;
    wen_i   = '0;
    add_i   = '0;
    wdata_i = '0;
    be_i    = '0;
  endtask

  initial begin
    clear_reqs();
    gnt_i = '1;
    for (int o = 0; o < NO; o++) rdata_i[o] = 32'hD000_0000 | o;
    rst_i = 1'b1;
    repeat (2) tick();

    // Outputs are forced low while reset is held, even with a request present.
    req_i[0] = 1'b1; add_i[0] = 32'h34; #1;
    check("rst_gnt", gnt_o[0], 4'b0000);
    check("rst_req", req_o[0], 8'h00);
    check("rst_vld", vld_o[0], 4'b0000);
    tick();
    rst_i = 1'b0; clear_reqs();
    tick();

    // A: init0 loads 0x34 and is decoded to bank 5 word 1, or bank 3 word 1 with 4-word interleaving.
    req_i[0] = 1'b1; add_i[0] = 32'h34; #1;
    check("a_req",        req_o[0], 8'h20);
    check("a_add",        add_o[0][5], 10'd1);
    check("a_gnt",        gnt_o[0], 4'b0001);
    check("a_req_ilv",    req_o[1], 8'h08);
    check("a_add_ilv",    add_o[1][3], 10'd1);
    check("a_gnt_pipe",   gnt_o[2], 4'b0001);
    check("a_req_pipe0",  req_o[2], 8'h00);
    tick(); clear_reqs(); #1;
    check("a_vld",        vld_o[0], 4'b0001);
    check("a_rdata",      rdata_o[0][0], 32'hD000_0005);
    check("a_rdata_idle", rdata_o[0][1], 32'h0);
    check("a_vld_ilv",    vld_o[1], 4'b0001);
    check("a_rdata_ilv",  rdata_o[1][0], 32'hD000_0003);
    check("a_req_pipe1",  req_o[2], 8'h20);
    check("a_add_pipe1",  add_o[2][5], 10'd1);
    check("a_vld_lat2_early", vld_o[4], 4'b0000);
    check("a_rr5",        gen_dut[0].u_dut.rr_q[5], 2'd1);
    tick();
    check("a_vld_once",   vld_o[0], 4'b0000);
    check("a_vld_pipe",   vld_o[2], 4'b0001);
    check("a_rdata_pipe", rdata_o[2][0], 32'hD000_0005);
    check("a_vld_lat2",   vld_o[4], 4'b0001);
    check("a_rdata_lat2", rdata_o[4][0], 32'hD000_0005);
    check("a_req_pipe2",  req_o[2], 8'h00);

    // B: init1 and init3 both target bank 2 and hold their requests for two cycles.
    req_i[1] = 1'b1; add_i[1] = 32'h08;
    req_i[3] = 1'b1; add_i[3] = 32'h08; #1;
    check("b_gnt_c0",   gnt_o[0], 4'b0010);
    check("b_req_bank", req_o[0], 8'h04);
    tick();
    check("b_rr_c0",    gen_dut[0].u_dut.rr_q[2], 2'd2);
    check("b_vld_c0",   vld_o[0], 4'b0010);
    check("b_rdata_c0", rdata_o[0][1], 32'hD000_0002);
    check("b_gnt_c1",   gnt_o[0], 4'b1000);
    check("b_gnt_c1_pipe", gnt_o[2], 4'b1000);
    tick(); clear_reqs(); #1;
    check("b_rr_c1",    gen_dut[0].u_dut.rr_q[2], 2'd0);
    check("b_vld_c1",   vld_o[0], 4'b1000);
    check("b_rdata_c1", rdata_o[0][3], 32'hD000_0002);
    repeat (3) tick();

    // C: bank 2 stalls for three cycles while init0 has a request pending on it.
    gnt_i = 8'hFB; req_i[0] = 1'b1; add_i[0] = 32'h08; #1;
    check("c_gnt_c0_pipe", gnt_o[2], 4'b0001);
    check("c_gnt_c0_comb", gnt_o[0], 4'b0000);
    check("c_req_c0_comb", req_o[0], 8'h04);
    tick(); add_i[0] = 32'h28; #1;
    check("c_gnt_c1_pipe", gnt_o[2], 4'b0000);
    check("c_req_c1_pipe", req_o[2], 8'h04);
    check("c_add_c1_pipe", add_o[2][2], 10'd0);
    tick();
    check("c_gnt_c2_pipe", gnt_o[2], 4'b0000);
    check("c_add_c2_pipe", add_o[2][2], 10'd0);
    check("c_vld_c2_pipe", vld_o[2], 4'b0000);
    tick(); gnt_i = '1; #1;
    check("c_gnt_c3_pipe", gnt_o[2], 4'b0001);
    check("c_add_c3_pipe", add_o[2][2], 10'd0);
    check("c_gnt_c3_comb", gnt_o[0], 4'b0001);
    tick(); clear_reqs(); #1;
    check("c_vld_first",   vld_o[2], 4'b0001);
    check("c_add_second",  add_o[2][2], 10'd1);
    check("c_req_second",  req_o[2], 8'h04);
    tick();
    check("c_vld_second",  vld_o[2], 4'b0001);
    check("c_req_drained", req_o[2], 8'h00);
    repeat (3) tick();

    // D: init2 stores to bank 4. Only WriteRespOn=1 instances give a response.
    req_i[2] = 1'b1; wen_i[2] = 1'b1; add_i[2] = 32'h10;
    wdata_i[2] = 32'hCAFE_F00D; be_i[2] = 4'b0110; #1;
    check("d_gnt_nowr", gnt_o[3], 4'b0100);
    check("d_gnt_wr",   gnt_o[4], 4'b0100);
    check("d_wen",      wen_o[0][4], 1'b1);
    check("d_wdata",    wdata_o[0][4], 32'hCAFE_F00D);
    check("d_be",       be_o[0][4], 4'b0110);
    check("d_add",      add_o[0][4], 10'd0);
    tick(); clear_reqs(); #1;
    check("d_vld_lat1",      vld_o[0], 4'b0100);
    check("d_vld_wr_early",  vld_o[4], 4'b0000);
    tick();
    check("d_vld_nowr",      vld_o[3], 4'b0000);
    check("d_vld_wr",        vld_o[4], 4'b0100);
    check("d_rdata_wr",      rdata_o[4][2], 32'hD000_0004);
    tick();
    check("d_vld_wr_once",   vld_o[4], 4'b0000);

    // E: reset is asserted the cycle after a granted load with RespLat=2.
    req_i[0] = 1'b1; add_i[0] = 32'h34; #1;
    check("e_gnt_pre", gnt_o[4], 4'b0001);
    tick();
    rst_i = 1'b1; clear_reqs(); req_i[1] = 1'b1; add_i[1] = 32'h04; #1;
    check("e_rst_gnt",   gnt_o[4], 4'b0000);
    check("e_rst_gnt0",  gnt_o[0], 4'b0000);
    check("e_rst_req",   req_o[4], 8'h00);
    check("e_rst_vld",   vld_o[4], 4'b0000);
    check("e_rst_vld0",  vld_o[0], 4'b0000);
    check("e_rst_rdata", rdata_o[0][0], 32'h0);
    tick();
    rst_i = 1'b0; clear_reqs(); #1;
    check("e_vld_rel0",  vld_o[4], 4'b0000);
    check("e_rr5",       gen_dut[0].u_dut.rr_q[5], 2'd0);
    check("e_rr2",       gen_dut[0].u_dut.rr_q[2], 2'd0);
    tick();
    check("e_vld_rel1",  vld_o[4], 4'b0000);
    check("e_vld_rel1b", vld_o[3], 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
